// File: rtl/triangle_vertex_loader.sv
// -----------------------------------------------------------------------------
// triangle_vertex_loader
//
// Upstream stage of draw_triangle. Takes a new triangle from the host as a
// six-word stream (x0, y0, x1, y1, x2, y2) and stores it in shadow registers,
// clamping each coordinate to the active area. The complete shadow triangle is
// committed to the outputs in one step on the next vsync rising edge, so the
// renderer never sees a half-updated triangle within a frame.
//
// Ports:
//   pixel_clk     sole clock
//   rst           asynchronous, active-high reset
//   s_data        stream word (unsigned coordinate)
//   s_valid       s_data valid
//   s_ready       loader accepts a word (state decode only)
//   video_vsync   vertical sync from draw_triangle
//   x0..y2        committed vertices, registered
//   pending       complete triangle in shadow, waiting for vsync
//   load_idx      index of the next expected word (0..5)
//   commit_pulse  one-cycle pulse after each commit
//   commit_count  commits since reset, wraps modulo 2^16
// -----------------------------------------------------------------------------
module triangle_vertex_loader #(
  parameter int H_ACTIVE_VIDEO = 1024,
  parameter int V_ACTIVE_VIDEO = 768,
  parameter int INIT_X0        = 100,
  parameter int INIT_Y0        = 100,
  parameter int INIT_X1        = 500,
  parameter int INIT_Y1        = 100,
  parameter int INIT_X2        = 300,
  parameter int INIT_Y2        = 400
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        video_vsync,
  output logic [31:0] x0,
  output logic [31:0] y0,
  output logic [31:0] x1,
  output logic [31:0] y1,
  output logic [31:0] x2,
  output logic [31:0] y2,
  output logic        pending,
  output logic [2:0]  load_idx,
  output logic        commit_pulse,
  output logic [15:0] commit_count
);

  typedef enum logic {
    ST_LOAD    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [31:0] X_MAX = 32'(H_ACTIVE_VIDEO - 1);
  localparam logic [31:0] Y_MAX = 32'(V_ACTIVE_VIDEO - 1);

  // Element i holds word i of the stream: 0=x0, 1=y0, 2=x1, 3=y1, 4=x2, 5=y2.
  localparam logic [5:0][31:0] INIT_VERTS = {
    32'(INIT_Y2), 32'(INIT_X2),
    32'(INIT_Y1), 32'(INIT_X1),
    32'(INIT_Y0), 32'(INIT_X0)
  };

  state_e            state_q, state_d;
  logic [2:0]        load_idx_q, load_idx_d;
  logic [5:0][31:0]  shadow_q, shadow_d;
  logic [5:0][31:0]  verts_q, verts_d;
  logic              vsync_prev_q, vsync_prev_d;
  logic              commit_pulse_q, commit_pulse_d;
  logic [15:0]       commit_count_q, commit_count_d;

  logic              vsync_rise;
  logic [31:0]       word_limit;
  logic [31:0]       word_clamped;

  assign vsync_rise   = video_vsync && !vsync_prev_q;
  // Even indices are x coordinates, odd indices are y coordinates.
  assign word_limit   = load_idx_q[0] ? Y_MAX : X_MAX;
  assign word_clamped = (s_data > word_limit) ? word_limit : s_data;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    load_idx_d     = load_idx_q;
    shadow_d       = shadow_q;
    verts_d        = verts_q;
    vsync_prev_d   = video_vsync;
    commit_pulse_d = 1'b0;
    commit_count_d = commit_count_q;

    unique case (state_q)
      ST_LOAD: begin
        // A vsync edge here is deliberately ignored: a partial triangle and its
        // index survive across frames until the sixth word arrives.
        if (s_valid) begin
          shadow_d[load_idx_q] = word_clamped;
          if (load_idx_q == 3'd5) begin
            load_idx_d = 3'd0;
            state_d    = ST_PENDING;
          end else begin
            load_idx_d = load_idx_q + 3'd1;
          end
        end
      end
      ST_PENDING: begin
        // vsync_prev_q is updated every cycle regardless of state, so an edge
        // that coincided with the sixth word is already consumed here.
        if (vsync_rise) begin
          verts_d        = shadow_q;
          state_d        = ST_LOAD;
          commit_pulse_d = 1'b1;
          commit_count_d = commit_count_q + 16'd1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  // NOTE: the shadow array is reset too (it is only six words), so a reset
  // mid-load leaves no stale coordinates behind.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_LOAD;
      load_idx_q     <= 3'd0;
      shadow_q       <= INIT_VERTS;
      verts_q        <= INIT_VERTS;
      vsync_prev_q   <= 1'b0;
      commit_pulse_q <= 1'b0;
      commit_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      load_idx_q     <= load_idx_d;
      shadow_q       <= shadow_d;
      verts_q        <= verts_d;
      vsync_prev_q   <= vsync_prev_d;
      commit_pulse_q <= commit_pulse_d;
      commit_count_q <= commit_count_d;
    end
  end

  // s_ready depends on the state register only, never on s_valid.
  assign s_ready      = (state_q == ST_LOAD);
  assign pending      = (state_q == ST_PENDING);
  assign load_idx     = load_idx_q;
  assign commit_pulse = commit_pulse_q;
  assign commit_count = commit_count_q;

  assign x0 = verts_q[0];
  assign y0 = verts_q[1];
  assign x1 = verts_q[2];
  assign y1 = verts_q[3];
  assign x2 = verts_q[4];
  assign y2 = verts_q[5];

endmodule

// File: tb/tb_triangle_vertex_loader.sv
// -----------------------------------------------------------------------------
// tb_triangle_vertex_loader
//
// Self-checking bench for triangle_vertex_loader. A behavioural model (shadow
// array, word counter, committed triangle, commit counter) follows the stream
// and vsync stimulus and predicts the full observable status, which is compared
// against the DUT after each step.
// -----------------------------------------------------------------------------
module tb_triangle_vertex_loader;

  localparam int H_ACT = 1024;
  localparam int V_ACT = 768;

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        video_vsync;
  logic [31:0] x0, y0, x1, y1, x2, y2;
  logic        pending;
  logic [2:0]  load_idx;
  logic        commit_pulse;
  logic [15:0] commit_count;

  triangle_vertex_loader dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .video_vsync  (video_vsync),
    .x0           (x0),
    .y0           (y0),
    .x1           (x1),
    .y1           (y1),
    .x2           (x2),
    .y2           (y2),
    .pending      (pending),
    .load_idx     (load_idx),
    .commit_pulse (commit_pulse),
    .commit_count (commit_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  int total  = 0;
  int passed = 0;

  // Reference model.
  logic [31:0] init_v [6];
  logic [31:0] m_shadow [6];
  logic [31:0] m_verts [6];
  int          m_idx;
  logic        m_pending;
  int          m_count;

  typedef logic [213:0] status_t;

  function automatic logic [31:0] clamp_ref(int idx, logic [31:0] w);
    logic [31:0] limit;
    limit = (idx % 2 == 0) ? 32'(H_ACT - 1) : 32'(V_ACT - 1);
    return (w > limit) ? limit : w;
  endfunction

  function automatic status_t observed();
    return {pending, s_ready, load_idx, commit_pulse, commit_count,
            y2, x2, y1, x1, y0, x0};
  endfunction

  function automatic status_t model_status(logic exp_pulse);
    return {m_pending, !m_pending, 3'(m_idx), exp_pulse, 16'(m_count),
            m_verts[5], m_verts[4], m_verts[3], m_verts[2], m_verts[1], m_verts[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_shadow[i] = init_v[i];
      m_verts[i]  = init_v[i];
    end
    m_idx     = 0;
    m_pending = 1'b0;
    m_count   = 0;
  endtask

  task automatic model_accept(logic [31:0] w);
    m_shadow[m_idx] = clamp_ref(m_idx, w);
    m_idx = (m_idx + 1) % 6;
    if (m_idx == 0) m_pending = 1'b1;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 6; i++) m_verts[i] = m_shadow[i];
    m_pending = 1'b0;
    m_count   = (m_count + 1) % 65536;
  endtask

  // Presents one word for exactly one rising edge while the loader is in LOAD;
  // s_valid stays high until the caller changes it on a later falling edge.
  task automatic send_word(logic [31:0] w);
    @(negedge pixel_clk);
    s_valid = 1'b1;
    s_data  = w;
    model_accept(w);
  endtask

  task automatic end_burst();
    @(negedge pixel_clk);
    s_valid = 1'b0;
  endtask

  // One vsync pulse: rises for one edge (commit expected or not), then falls.
  task automatic vsync_rise(string name, logic expect_commit);
    status_t exp;
    @(negedge pixel_clk);
    video_vsync = 1'b1;
    @(negedge pixel_clk);
    if (expect_commit) model_commit();
    exp = model_status(expect_commit);
    total++;
    if (observed() !== exp)
      $display("FAIL %s_edge: got %h expected %h", name, observed(), exp);
    else passed++;
    @(negedge pixel_clk);
    video_vsync = 1'b0;
    exp = model_status(1'b0);
    total++;
    if (observed() !== exp)
      $display("FAIL %s_after: got %h expected %h", name, observed(), exp);
    else passed++;
  endtask

  task automatic test_reset();
    status_t exp;
    rst         = 1'b1;
    s_valid     = 1'b1;
    s_data      = 32'd55;
    video_vsync = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge pixel_clk);
      video_vsync = ~video_vsync;
    end
    exp = model_status(1'b0);
    total++;
    if (observed() !== exp)
      $display("FAIL reset_held: got %h expected %h", observed(), exp);
    else passed++;
    @(negedge pixel_clk);
    s_valid     = 1'b0;
    video_vsync = 1'b0;
    rst         = 1'b0;
    @(negedge pixel_clk);
    total++;
    if (observed() !== exp)
      $display("FAIL reset_released: got %h expected %h", observed(), exp);
    else passed++;
  endtask

  task automatic load_six(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2,
                          logic [31:0] w3, logic [31:0] w4, logic [31:0] w5);
    send_word(w0); send_word(w1); send_word(w2);
    send_word(w3); send_word(w4); send_word(w5);
    end_burst();
  endtask

  task automatic check_status(string name);
    status_t exp;
    exp = model_status(1'b0);
    total++;
    if (observed() !== exp)
      $display("FAIL %s: got %h expected %h", name, observed(), exp);
    else passed++;
  endtask

  task automatic test_basic();
    load_six(10, 20, 1000, 30, 500, 700);
    check_status("basic_pending");
    vsync_rise("basic_commit", 1'b1);
  endtask

  task automatic test_clamp();
    load_six(5000, 900, 0, 0, 1023, 767);
    check_status("clamp_pending");
    vsync_rise("clamp_commit", 1'b1);
    load_six(1024, 768, 1022, 766, 32'hFFFF_FFFF, 32'h8000_0000);
    vsync_rise("clamp_bounds", 1'b1);
  endtask

  task automatic test_backpressure();
    status_t exp;
    load_six(11, 12, 13, 14, 15, 16);
    @(negedge pixel_clk);
    s_valid = 1'b1;
    s_data  = 32'd7;
    repeat (30) @(negedge pixel_clk);
    check_status("bp_hold");
    video_vsync = 1'b1;
    @(negedge pixel_clk);
    model_commit();
    exp = model_status(1'b1);
    total++;
    if (observed() !== exp)
      $display("FAIL bp_commit: got %h expected %h", observed(), exp);
    else passed++;
    model_accept(32'd7);
    @(negedge pixel_clk);
    s_valid     = 1'b0;
    video_vsync = 1'b0;
    check_status("bp_accept_x0");
    send_word(21); send_word(22); send_word(23); send_word(24); send_word(25);
    end_burst();
    vsync_rise("bp_x0_seven", 1'b1);
  endtask

  task automatic test_partial();
    send_word(31); send_word(32); send_word(33);
    end_burst();
    vsync_rise("partial_a", 1'b0);
    vsync_rise("partial_b", 1'b0);
    send_word(34); send_word(35); send_word(36);
    end_burst();
    check_status("partial_full");
    vsync_rise("partial_commit", 1'b1);
  endtask

  task automatic test_simultaneous();
    send_word(41); send_word(42); send_word(43); send_word(44); send_word(45);
    @(negedge pixel_clk);
    s_valid     = 1'b1;
    s_data      = 32'd46;
    video_vsync = 1'b1;
    model_accept(32'd46);
    @(negedge pixel_clk);
    s_valid = 1'b0;
    check_status("simul_no_commit");
    repeat (4) @(negedge pixel_clk);
    check_status("simul_vsync_high");
    video_vsync = 1'b0;
    vsync_rise("simul_next_frame", 1'b1);
  endtask

  task automatic test_reset_midload();
    send_word(51); send_word(52); send_word(53);
    end_burst();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_status("rst_async");
    @(negedge pixel_clk);
    rst = 1'b0;
    @(negedge pixel_clk);
    check_status("rst_released");
    load_six(61, 62, 63, 64, 65, 66);
    vsync_rise("rst_reload", 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge pixel_clk);
          s_valid     = 1'b0;
          video_vsync = 1'($urandom_range(0, 1));
        end
        w = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1100));
        send_word(w);
      end
      @(negedge pixel_clk);
      s_valid     = 1'b0;
      video_vsync = 1'b0;
      check_status("rand_pending");
      vsync_rise("rand_commit", 1'b1);
    end
  endtask

  initial begin
    init_v[0] = 32'd100; init_v[1] = 32'd100;
    init_v[2] = 32'd500; init_v[3] = 32'd100;
    init_v[4] = 32'd300; init_v[5] = 32'd400;
    test_reset();
    test_basic();
    test_clamp();
    test_backpressure();
    test_partial();
    test_simultaneous();
    test_reset_midload();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
